uart_rx_ab: RTL and testbench

//  Next-generation UART receiver: runtime-configurable frame (5..DBIT data bits, none/even/odd parity, fractional stop),
//  per-word error tagging in the RX FIFO, break detection, and hardware auto-baud measurement on a sync character.

---
 rtl/uart_rx_ab_pkg.sv | 30 +++
 rtl/uart_rx_ab_fifo.sv | 45 ++++
 rtl/uart_rx_ab.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_uart_rx_ab.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_ab_pkg.sv
// Shared definitions for the auto-baud UART receiver: parity codes, FSM states, oversample log2.
package uart_rx_ab_pkg;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_PUSH,
    ST_BRK,
    ST_AB_WAIT,
    ST_AB_MEAS,
    ST_AB_IDLE
  } rx_state_t;

  // Shift amount that divides by the oversample rate; only 8/16/32 are legal, others act as 16.
  function automatic logic [2:0] os_log2(input logic [7:0] os);
    case (os)
      8'd8:    os_log2 = 3'd3;
      8'd32:   os_log2 = 3'd5;
      default: os_log2 = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_ab_fifo.sv
// Synchronous first-word-fall-through FIFO holding received words with their error tags.
module uart_rx_ab_fifo #(
  parameter int W  = 10,
  parameter int AW = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         wr,
  input  logic [W-1:0] w_data,
  input  logic         rd,
  output logic [W-1:0] r_data,
  output logic         empty,
  output logic         full
);

  logic [W-1:0] mem [0:2**AW-1];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic         rd_en;
  logic         wr_en;

  assign empty  = (wptr == rptr);
  assign full   = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rd_en  = rd & ~empty;
  // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
  assign wr_en  = wr & (~full | rd_en);
  assign r_data = empty ? '0 : mem[rptr[AW-1:0]];

  // pointer update; the extra MSB distinguishes full from empty
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (rd_en) rptr <= rptr + 1'b1;
    end
  end

  // storage array, not reset; validity is tracked by the pointers
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr[AW-1:0]] <= w_data;
  end

endmodule

// File: rtl/uart_rx_ab.sv
// UART receiver with configurable frame, tagged RX FIFO, break detection and auto-baud measurement.
//
// state      | meaning
// IDLE       | line idle, waiting for start edge or auto-baud arm
// START      | counting to mid start bit, glitch reject
// DATA       | sampling dbit data bits, LSB first
// PARITY     | sampling parity bit
// STOP       | sampling stop bit, waiting sb_tick ticks
// PUSH       | one cycle: write tagged word into FIFO
// BRK        | break seen, waiting for rx high os_tick ticks
// AB_WAIT    | auto-baud armed, waiting for falling edge
// AB_MEAS    | counting clocks while rx low
// AB_IDLE    | discarding rest of sync char until rx high 2*cnt cycles
module uart_rx_ab
  import uart_rx_ab_pkg::*;
#(
  parameter int DBIT     = 8,
  parameter int DVSR_BIT = 8,
  parameter int FIFO_W   = 4,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                rx,
  input  logic [3:0]          dbit,
  input  logic [1:0]          pbit,
  input  logic [7:0]          sb_tick,
  input  logic [7:0]          os_tick,
  input  logic [DVSR_BIT-1:0] dvsr,
  input  logic                ab_start,
  input  logic                ab_use,
  input  logic                rd_uart,
  output logic [DBIT-1:0]     r_data,
  output logic                r_perr,
  output logic                r_ferr,
  output logic                rx_ready,
  output logic                rx_empty,
  output logic                rx_done_tick,
  output logic                e_parity,
  output logic                e_frame,
  output logic                e_rxof,
  output logic                e_break,
  output logic                ab_busy,
  output logic                ab_done,
  output logic                e_ab,
  output logic [DVSR_BIT-1:0] dvsr_meas
);

  localparam logic [3:0] DBIT_MAX = 4'(DBIT);

  rx_state_t state, state_nxt;

  logic                rx_s1, rx_s2, rx_prev, fall;
  logic [DVSR_BIT-1:0] tcnt, div_l, div_sel, div_c;
  logic                s_tick;
  logic [3:0]          dbit_l, dbit_c;
  logic [1:0]          pbit_l;
  logic [7:0]          sb_l, os_l, os_m1, half_m1, sb_m1;
  logic                par_en;
  logic [7:0]          s_cnt, s_cnt_nxt;
  logic [3:0]          n_cnt, n_cnt_nxt;
  logic [DBIT-1:0]     data_r, data_nxt;
  logic                par_r, par_nxt, stop_r, stop_v;
  logic [CNT_W-1:0]    ab_cnt, ab_cnt_nxt;
  logic [CNT_W:0]      hi_cnt, hi_cnt_nxt, ab_sum, ab_q;
  logic                ab_q_ok;
  logic                cfg_load, meas_load, push, brk_pulse, is_brk;
  logic                perr, ferr;
  logic                fifo_full;
  logic [DBIT+1:0]     head;

  assign fall    = rx_prev & ~rx_s2;
  assign div_sel = ab_use ? dvsr_meas : dvsr;
  assign div_c   = (div_sel == '0) ? DVSR_BIT'(1) : div_sel;
  assign dbit_c  = (dbit > DBIT_MAX) ? DBIT_MAX : ((dbit < 4'd5) ? 4'd5 : dbit);
  assign s_tick  = (state != ST_IDLE) && (tcnt == div_l - DVSR_BIT'(1));
  assign os_m1   = os_l - 8'd1;
  assign half_m1 = (os_l >> 1) - 8'd1;
  assign sb_m1   = sb_l - 8'd1;
  assign par_en  = (pbit_l == PAR_EVEN) || (pbit_l == PAR_ODD);
  assign stop_v  = (state == ST_STOP && s_tick && s_cnt == os_m1) ? rx_s2 : stop_r;
  assign is_brk  = ~stop_v & (data_r == '0) & (~par_en | ~par_r);
  assign perr    = par_en & ((^data_r ^ par_r) != (pbit_l == PAR_ODD));
  assign ferr    = ~stop_r;
  assign ab_sum  = {1'b0, ab_cnt} + (CNT_W+1)'(os_l >> 1);
  assign ab_q    = ab_sum >> os_log2(os_l);
  assign ab_q_ok = (ab_q != '0) && (ab_q[CNT_W:DVSR_BIT] == '0) && (ab_cnt != '1);

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // next-state and datapath-next decode
  always_comb begin
    state_nxt  = state;
    s_cnt_nxt  = s_cnt;
    n_cnt_nxt  = n_cnt;
    data_nxt   = data_r;
    par_nxt    = par_r;
    ab_cnt_nxt = ab_cnt;
    hi_cnt_nxt = hi_cnt;
    cfg_load   = 1'b0;
    meas_load  = 1'b0;
    push       = 1'b0;
    brk_pulse  = 1'b0;
    ab_done    = 1'b0;
    e_ab       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ab_start) begin
          cfg_load  = 1'b1;
          state_nxt = ST_AB_WAIT;
        end else if (fall) begin
          cfg_load  = 1'b1;
          s_cnt_nxt = '0;
          n_cnt_nxt = '0;
          data_nxt  = '0;
          par_nxt   = 1'b0;
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (s_tick) begin
          if (s_cnt == half_m1) begin
            s_cnt_nxt = '0;
            state_nxt = rx_s2 ? ST_IDLE : ST_DATA;
          end else begin
            s_cnt_nxt = s_cnt + 8'd1;
          end
        end
      end
      ST_DATA: begin
        if (s_tick) begin
          if (s_cnt == os_m1) begin
            s_cnt_nxt = '0;
            for (int i = 0; i < DBIT; i++)
              if (n_cnt == 4'(i)) data_nxt[i] = rx_s2;
            n_cnt_nxt = n_cnt + 4'd1;
            if (n_cnt == dbit_l - 4'd1) state_nxt = par_en ? ST_PARITY : ST_STOP;
          end else begin
            s_cnt_nxt = s_cnt + 8'd1;
          end
        end
      end
      ST_PARITY: begin
        if (s_tick) begin
          if (s_cnt == os_m1) begin
            s_cnt_nxt = '0;
            par_nxt   = rx_s2;
            state_nxt = ST_STOP;
          end else begin
            s_cnt_nxt = s_cnt + 8'd1;
          end
        end
      end
      ST_STOP: begin
        if (s_tick) begin
          if (s_cnt == sb_m1) begin
            s_cnt_nxt = '0;
            if (is_brk) begin
              brk_pulse = 1'b1;
              state_nxt = ST_BRK;
            end else begin
              state_nxt = ST_PUSH;
            end
          end else begin
            s_cnt_nxt = s_cnt + 8'd1;
          end
        end
      end
      ST_PUSH: begin
        push      = 1'b1;
        state_nxt = ST_IDLE;
      end
      ST_BRK: begin
        if (!rx_s2) begin
          s_cnt_nxt = '0;
        end else if (s_tick) begin
          if (s_cnt == os_m1) begin
            s_cnt_nxt = '0;
            state_nxt = ST_IDLE;
          end else begin
            s_cnt_nxt = s_cnt + 8'd1;
          end
        end
      end
      ST_AB_WAIT: begin
        if (fall) begin
          ab_cnt_nxt = CNT_W'(1);
          state_nxt  = ST_AB_MEAS;
        end
      end
      ST_AB_MEAS: begin
        if (!rx_s2) begin
          if (ab_cnt != '1) ab_cnt_nxt = ab_cnt + CNT_W'(1);
        end else begin
          if (ab_q_ok) begin
            meas_load = 1'b1;
            ab_done   = 1'b1;
          end else begin
            e_ab = 1'b1;
          end
          hi_cnt_nxt = '0;
          state_nxt  = ST_AB_IDLE;
        end
      end
      ST_AB_IDLE: begin
        if (!rx_s2)                       hi_cnt_nxt = '0;
        else if (hi_cnt >= {ab_cnt, 1'b0}) state_nxt = ST_IDLE;
        else                              hi_cnt_nxt = hi_cnt + 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // rx synchroniser, baud tick counter, frame datapath and configuration latches
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      rx_prev   <= 1'b1;
      tcnt      <= '0;
      div_l     <= DVSR_BIT'(1);
      dbit_l    <= DBIT_MAX;
      pbit_l    <= PAR_NONE;
      sb_l      <= 8'd16;
      os_l      <= 8'd16;
      s_cnt     <= '0;
      n_cnt     <= '0;
      data_r    <= '0;
      par_r     <= 1'b0;
      stop_r    <= 1'b1;
      ab_cnt    <= '0;
      hi_cnt    <= '0;
      dvsr_meas <= '0;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      if (state == ST_IDLE || tcnt == div_l - DVSR_BIT'(1)) tcnt <= '0;
      else                                                 tcnt <= tcnt + DVSR_BIT'(1);
      if (cfg_load) begin
        div_l  <= div_c;
        dbit_l <= dbit_c;
        pbit_l <= pbit;
        sb_l   <= sb_tick;
        os_l   <= os_tick;
      end
      s_cnt  <= s_cnt_nxt;
      n_cnt  <= n_cnt_nxt;
      data_r <= data_nxt;
      par_r  <= par_nxt;
      stop_r <= (state == ST_IDLE) ? 1'b1 : stop_v;
      ab_cnt <= ab_cnt_nxt;
      hi_cnt <= hi_cnt_nxt;
      if (meas_load) dvsr_meas <= ab_q[DVSR_BIT-1:0];
    end
  end

  uart_rx_ab_fifo #(
    .W  (DBIT + 2),
    .AW (FIFO_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr      (push),
    .w_data  ({ferr, perr, data_r}),
    .rd      (rd_uart),
    .r_data  (head),
    .empty   (rx_empty),
    .full    (fifo_full)
  );

  assign r_data       = head[DBIT-1:0];
  assign r_perr       = head[DBIT];
  assign r_ferr       = head[DBIT+1];
  assign rx_ready     = ~rx_empty;
  assign rx_done_tick = push & (~fifo_full | rd_uart);
  assign e_rxof       = push & fifo_full & ~rd_uart;
  assign e_parity     = push & perr;
  assign e_frame      = push & ferr;
  assign e_break      = brk_pulse;
  assign ab_busy      = (state == ST_AB_WAIT) || (state == ST_AB_MEAS) || (state == ST_AB_IDLE);

endmodule

// File: tb/tb_uart_rx_ab.sv
// Directed bench for uart_rx_ab: FIFO fill/overflow, parity, frame error, break, auto-baud, mid-frame reset.
module tb_uart_rx_ab;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       rx;
  logic [3:0] dbit;
  logic [1:0] pbit;
  logic [7:0] sb_tick, os_tick, dvsr;
  logic       ab_start, ab_use, rd_uart;
  logic [7:0] r_data;
  logic       r_perr, r_ferr, rx_ready, rx_empty, rx_done_tick;
  logic       e_parity, e_frame, e_rxof, e_break, ab_busy, ab_done, e_ab;
  logic [7:0] dvsr_meas;

  int checks = 0;
  int errors = 0;
  int n_done = 0, n_par = 0, n_frm = 0, n_of = 0, n_brk = 0, n_abd = 0, n_eab = 0;
  int base;

  always #10 clk = ~clk;

  uart_rx_ab dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rx           (rx),
    .dbit         (dbit),
    .pbit         (pbit),
    .sb_tick      (sb_tick),
    .os_tick      (os_tick),
    .dvsr         (dvsr),
    .ab_start     (ab_start),
    .ab_use       (ab_use),
    .rd_uart      (rd_uart),
    .r_data       (r_data),
    .r_perr       (r_perr),
    .r_ferr       (r_ferr),
    .rx_ready     (rx_ready),
    .rx_empty     (rx_empty),
    .rx_done_tick (rx_done_tick),
    .e_parity     (e_parity),
    .e_frame      (e_frame),
    .e_rxof       (e_rxof),
    .e_break      (e_break),
    .ab_busy      (ab_busy),
    .ab_done      (ab_done),
    .e_ab         (e_ab),
    .dvsr_meas    (dvsr_meas)
  );

  // pulse counters, sampled mid-cycle
  always @(negedge clk) begin
    if (rx_done_tick) n_done++;
    if (e_parity)     n_par++;
    if (e_frame)      n_frm++;
    if (e_rxof)       n_of++;
    if (e_break)      n_brk++;
    if (ab_done)      n_abd++;
    if (e_ab)         n_eab++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // pm: 0 none, 1 even, 2 odd
  task automatic send_frame(input logic [7:0] d, input int nb, input int pm,
                            input bit bad_par, input bit stop_val, input int bt);
    logic [7:0] m;
    logic       p;
    m = d & 8'((1 << nb) - 1);
    p = ^m;
    if (pm == 2) p = ~p;
    if (bad_par) p = ~p;
    drive_bit(1'b0, bt);
    for (int i = 0; i < nb; i++) drive_bit(m[i], bt);
    if (pm == 1 || pm == 2) drive_bit(p, bt);
    drive_bit(stop_val, bt);
    drive_bit(1'b1, 2 * bt);
  endtask

  task automatic pop();
    rd_uart = 1'b1;
    @(posedge clk); #1;
    rd_uart = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic set_cfg(input logic [7:0] dv, input logic [7:0] os, input logic [7:0] sb,
                         input logic [1:0] pb, input logic [3:0] db);
    dvsr = dv; os_tick = os; sb_tick = sb; pbit = pb; dbit = db;
  endtask

  task automatic wait_ab_idle(input string tag);
    for (int i = 0; i < 5000; i++) begin
      if (!ab_busy) break;
      @(posedge clk); #1;
    end
    chk(tag, ab_busy, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0; rx = 1'b1; ab_start = 1'b0; ab_use = 1'b0; rd_uart = 1'b0;
    set_cfg(8'd2, 8'd8, 8'd8, 2'd0, 4'd8);
    repeat (5) @(posedge clk); #1;
    chk("rst_empty", rx_empty, 1'b1);
    chk("rst_ready", rx_ready, 1'b0);
    chk("rst_head", {r_ferr, r_perr, r_data}, 10'h000);
    chk("rst_pulses", {rx_done_tick, e_parity, e_frame, e_rxof, e_break, ab_done, e_ab}, 7'h00);
    chk("rst_ab", {ab_busy, dvsr_meas}, 9'h000);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // fill the 16-deep FIFO at 16 clk/bit, then overflow once
    for (int i = 1; i <= 16; i++) send_frame(8'(i), 8, 0, 1'b0, 1'b1, 16);
    chk("fill_done", n_done, 16);
    chk("fill_ready", rx_ready, 1'b1);
    chk("fill_errs", n_par + n_frm + n_of + n_brk, 0);
    send_frame(8'h11, 8, 0, 1'b0, 1'b1, 16);
    chk("ovf_rxof", n_of, 1);
    chk("ovf_done", n_done, 16);
    for (int i = 1; i <= 16; i++) begin
      chk("fifo_order", {r_ferr, r_perr, r_data}, {2'b00, 8'(i)});
      pop();
    end
    chk("drain_empty", {rx_empty, rx_ready}, 2'b10);
    chk("drain_head", r_data, 8'h00);

    // odd parity, 7 data bits, 1.5 stop, 416 clk/bit, wrong parity bit
    set_cfg(8'd13, 8'd32, 8'd48, 2'd2, 4'd7);
    base = n_par;
    send_frame(8'hA5, 7, 2, 1'b1, 1'b1, 416);
    chk("par_data", r_data, 8'h25);
    chk("par_flags", {r_ferr, r_perr}, 2'b01);
    chk("par_pulse", n_par - base, 1);
    pop();

    // even parity, 5 data bits, correct parity
    set_cfg(8'd2, 8'd8, 8'd8, 2'd1, 4'd5);
    send_frame(8'h13, 5, 1, 1'b0, 1'b1, 16);
    chk("dbit5_word", {r_ferr, r_perr, r_data}, {2'b00, 8'h13});
    chk("dbit5_nopar", n_par - base, 1);
    pop();

    // frame error: non-zero data, stop bit low
    set_cfg(8'd2, 8'd8, 8'd8, 2'd0, 4'd8);
    send_frame(8'h81, 8, 0, 1'b0, 1'b0, 16);
    chk("ferr_word", {r_ferr, r_perr, r_data}, {2'b10, 8'h81});
    chk("ferr_pulse", n_frm, 1);
    chk("ferr_nobrk", n_brk, 0);
    pop();

    // break: line low 12 bit times at 160 clk/bit, then a normal frame
    set_cfg(8'd10, 8'd16, 8'd24, 2'd0, 4'd8);
    base = n_done;
    drive_bit(1'b0, 12 * 160);
    drive_bit(1'b1, 2 * 160);
    chk("brk_pulse", n_brk, 1);
    chk("brk_nopush", n_done - base, 0);
    chk("brk_noferr", n_frm, 1);
    send_frame(8'h3C, 8, 0, 1'b0, 1'b1, 160);
    chk("brk_next", {r_ferr, r_perr, r_data}, {2'b00, 8'h3C});
    pop();

    // auto-baud on 0x55 at 416 clk/bit, os 32 -> (416+16)>>5 = 13
    set_cfg(8'd2, 8'd32, 8'd32, 2'd0, 4'd8);
    base = n_done;
    ab_start = 1'b1;
    @(posedge clk); #1;
    ab_start = 1'b0;
    chk("ab_busy", ab_busy, 1'b1);
    send_frame(8'h55, 8, 0, 1'b0, 1'b1, 416);
    wait_ab_idle("ab_timeout");
    chk("ab_done", n_abd, 1);
    chk("ab_meas", dvsr_meas, 8'd13);
    chk("ab_nopush", n_done - base, 0);
    ab_use = 1'b1;
    dvsr = 8'd0;
    send_frame(8'h7E, 8, 0, 1'b0, 1'b1, 416);
    chk("ab_use_rx", {r_ferr, r_perr, r_data}, {2'b00, 8'h7E});
    pop();
    chk("ab_use_empty", rx_empty, 1'b1);

    // 10-clk low pulse -> (10+16)>>5 = 0, out of range
    ab_start = 1'b1;
    @(posedge clk); #1;
    ab_start = 1'b0;
    drive_bit(1'b0, 10);
    drive_bit(1'b1, 40);
    wait_ab_idle("eab_timeout");
    chk("eab_pulse", n_eab, 1);
    chk("eab_keep", dvsr_meas, 8'd13);
    chk("eab_nodone", n_abd, 1);

    // reset in the middle of a data bit
    ab_use = 1'b0;
    set_cfg(8'd2, 8'd8, 8'd8, 2'd0, 4'd8);
    send_frame(8'h5A, 8, 0, 1'b0, 1'b1, 16);
    chk("pre_rst_ready", rx_ready, 1'b1);
    drive_bit(1'b0, 16);
    drive_bit(1'b1, 16);
    drive_bit(1'b0, 16);
    drive_bit(1'b1, 8);
    base = n_done;
    reset_n = 1'b0;
    rx = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("mid_rst_fifo", {rx_empty, rx_ready, r_data}, {2'b10, 8'h00});
    chk("mid_rst_ab", {ab_busy, dvsr_meas}, 9'h000);
    reset_n = 1'b1;
    drive_bit(1'b1, 48);
    chk("mid_rst_nopush", n_done - base, 0);
    send_frame(8'hC3, 8, 0, 1'b0, 1'b1, 16);
    chk("post_rst_word", {r_ferr, r_perr, r_data}, {2'b00, 8'hC3});
    pop();
    chk("post_rst_empty", rx_empty, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
